f_stage: RTL

- Fetch stage of the pipelined MIPS CPU. It is the producer side of the F/D pipeline register.
- Owns the PC register and runs a req/ready handshake with instruction memory.
- Drives PC, PC8 and instr into F/D. Honours the F/D enable (stall) from the hazard unit.
- Applies branch/jump redirects from D while preserving the delay slot.
- Emits a NOP bubble (32'h0) whenever no fetched instruction is available.

---
 rtl/f_stage_pkg.sv | 17 +
 rtl/f_stage.sv | 87 ++++++++
 2 files changed

// File: rtl/f_stage_pkg.sv
// rtl/f_stage_pkg.sv - shared CPU constants and fetch state encoding
package f_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    REQ  = 1'b0,
    HAVE = 1'b1
  } fetch_state_t;

  // Clears the byte-offset bits so every stored fetch target is a word address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/f_stage.sv
// rtl/f_stage.sv - MIPS fetch stage: PC register, imem handshake, delay-slot redirects
module f_stage
  import f_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] PC8,
  output logic [31:0] instr,
  output logic        fetch_valid
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ibuf_q, ibuf_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_pc_q, pend_pc_d;

  assign PC          = pc_q;
  assign PC8         = pc_q + 32'd8;
  assign imem_addr   = pc_q;
  assign fetch_valid = (state_q == HAVE);
  assign instr       = fetch_valid ? ibuf_q : NOP_INSTR;
  assign imem_req    = (state_q == REQ) && reset;

  // Next-state logic: capture on ready, advance PC on transfer, remember redirects that arrive before the delay slot.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ibuf_d       = ibuf_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    case (state_q)
      REQ: begin
        // Capture does not depend on en: the buffer just fills while F/D may be stalled.
        if (imem_ready) begin
          ibuf_d  = imem_rdata;
          state_d = HAVE;
        end
        // Branch moved on to E before its delay slot arrived; apply the target after the slot transfers.
        if (en && redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = word_align(redirect_pc);
        end
      end
      HAVE: begin
        // With en low the branch in D is stalled too and will re-assert redirect later.
        if (en) begin
          if (redirect)          pc_d = word_align(redirect_pc);
          else if (pend_valid_q) pc_d = pend_pc_q;
          else                   pc_d = pc_q + 32'd4;
          pend_valid_d = 1'b0;
          state_d      = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  // State registers with synchronous active-low reset; imem_ready is ignored during reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= REQ;
      pc_q         <= RESET_PC;
      ibuf_q       <= 32'h0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ibuf_q       <= ibuf_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

endmodule
